// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Accept in IDLE, drive the ALU for one EXEC cycle, then hold a registered response until consumed.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ALUControl_WIDTH = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [DATA_WIDTH-1:0]       req0_srca,
  input  logic [DATA_WIDTH-1:0]       req0_srcb,
  input  logic [ALUControl_WIDTH-1:0] req0_ctrl,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [DATA_WIDTH-1:0]       req1_srca,
  input  logic [DATA_WIDTH-1:0]       req1_srcb,
  input  logic [ALUControl_WIDTH-1:0] req1_ctrl,
  output logic                        rsp0_valid,
  input  logic                        rsp0_ready,
  output logic                        rsp1_valid,
  input  logic                        rsp1_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_zero,
  output logic [DATA_WIDTH-1:0]       alu_srca,
  output logic [DATA_WIDTH-1:0]       alu_srcb,
  output logic [ALUControl_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0]       alu_out,
  input  logic                        alu_zero,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                      state, state_next;
  logic                        grant, load, capture;
  logic                        last_grant, owner;
  logic [DATA_WIDTH-1:0]       op_a, op_b;
  logic [ALUControl_WIDTH-1:0] op_ctrl;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Grant is only meaningful in IDLE; on contention the requester not granted last time wins.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        if (req0_valid || req1_valid) begin
          load       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if ((!owner && rsp0_ready) || (owner && rsp1_ready)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (load) begin
        owner      <= grant;
        last_grant <= grant;
        op_a       <= grant ? req1_srca : req0_srca;
        op_b       <= grant ? req1_srcb : req0_srcb;
        op_ctrl    <= grant ? req1_ctrl : req0_ctrl;
      end
      if (capture) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
      end
      // owner is already settled by the EXEC cycle, so it selects the response lane here.
      rsp0_valid <= (state_next == RESP) && !owner;
      rsp1_valid <= (state_next == RESP) && owner;
      busy       <= (state_next != IDLE);
    end
  end

  assign alu_srca = op_a;
  assign alu_srcb = op_b;
  assign alu_ctrl = op_ctrl;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model on the shared port.
module tb_alu_share_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  logic          CLK, RST;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [CW-1:0] req0_ctrl, req1_ctrl;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_data, alu_srca, alu_srcb, alu_out;
  logic          rsp_zero, alu_zero, busy;
  logic [CW-1:0] alu_ctrl;

  int vectors = 0;
  int miscompares = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .ALUControl_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca),
    .req0_srcb(req0_srcb), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca),
    .req1_srcb(req1_srcb), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External ALU: 000 and, 001 or, 010 add, 100 sub, 101 mul, 110 slt, others return 0.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_out = alu_srca & alu_srcb;
      3'b001:  alu_out = alu_srca | alu_srcb;
      3'b010:  alu_out = alu_srca + alu_srcb;
      3'b100:  alu_out = alu_srca - alu_srcb;
      3'b101:  alu_out = DW'(alu_srca * alu_srcb);
      3'b110:  alu_out = DW'($signed(alu_srca) < $signed(alu_srcb));
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_srca = '0; req0_srcb = '0; req0_ctrl = '0;
    req1_srca = '0; req1_srcb = '0; req1_ctrl = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 0; #12;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid}); end
    vectors++; if ({rsp_data, rsp_zero} !== '0) begin miscompares++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_data, rsp_zero); end
    vectors++; if ({alu_srca, alu_srcb, alu_ctrl} !== '0) begin miscompares++; $display("FAIL reset_alu got %h %h %b want 0", alu_srca, alu_srcb, alu_ctrl); end
    @(negedge CLK); RST = 1;
    tick();
  endtask

  // One request from requester `who`, response consumed immediately; checks 3-cycle handshake.
  task automatic test_op(input bit who, input logic [CW-1:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] ed, input logic ez);
    if (!who) begin req0_valid = 1; req0_srca = a; req0_srcb = b; req0_ctrl = c; end
    else begin req1_valid = 1; req1_srca = a; req1_srcb = b; req1_ctrl = c; end
    #1;
    vectors++; if ({req1_ready, req0_ready} !== (who ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL op_accept got %b want %b", {req1_ready, req0_ready}, who ? 2'b10 : 2'b01); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL op_busy_T got %b want 0", busy); end
    tick(); req0_valid = 0; req1_valid = 0;
    vectors++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin miscompares++; $display("FAIL op_exec got %b want 100", {busy, rsp0_valid, rsp1_valid}); end
    vectors++; if ({alu_srca, alu_srcb, alu_ctrl} !== {a, b, c}) begin miscompares++; $display("FAIL op_alu_drive got %h %h %b want %h %h %b", alu_srca, alu_srcb, alu_ctrl, a, b, c); end
    tick();
    vectors++; if ({busy, rsp0_valid, rsp1_valid} !== (who ? 3'b101 : 3'b110)) begin miscompares++; $display("FAIL op_rsp_valid got %b want %b", {busy, rsp0_valid, rsp1_valid}, who ? 3'b101 : 3'b110); end
    vectors++; if ({rsp_data, rsp_zero} !== {ed, ez}) begin miscompares++; $display("FAIL op_rsp got %h/%b want %h/%b", rsp_data, rsp_zero, ed, ez); end
    tick();
    vectors++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin miscompares++; $display("FAIL op_retire got %b want 000", {busy, rsp0_valid, rsp1_valid}); end
    vectors++; if ({alu_srca, alu_srcb, alu_ctrl} !== {a, b, c}) begin miscompares++; $display("FAIL op_alu_hold got %h %h %b", alu_srca, alu_srcb, alu_ctrl); end
  endtask

  task automatic test_reset_mid();
    req1_valid = 1; req1_srca = 32'd5; req1_srcb = 32'd7; req1_ctrl = 3'b010;
    tick(); req1_valid = 0;
    vectors++; if (alu_srca !== 32'd5) begin miscompares++; $display("FAIL mid_exec_srca got %h want 5", alu_srca); end
    #2; RST = 0; #1;
    vectors++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin miscompares++; $display("FAIL mid_reset_ctl got %b want 000", {busy, rsp0_valid, rsp1_valid}); end
    vectors++; if ({rsp_data, rsp_zero} !== '0) begin miscompares++; $display("FAIL mid_reset_rsp got %h/%b want 0/0", rsp_data, rsp_zero); end
    vectors++; if ({alu_srca, alu_srcb, alu_ctrl} !== '0) begin miscompares++; $display("FAIL mid_reset_alu got %h %h %b want 0", alu_srca, alu_srcb, alu_ctrl); end
    req0_valid = 1; req1_valid = 1;
    #1; RST = 1; #1;
    vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL mid_regrant got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int got[$];
    RST = 0; #3; RST = 1;
    req0_valid = 1; req0_srca = 32'd9;    req0_srcb = 32'd9;    req0_ctrl = 3'b100;
    req1_valid = 1; req1_srca = 32'hF0;   req1_srcb = 32'h0F;   req1_ctrl = 3'b001;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      #1;
      if (req0_ready) got.push_back(0);
      if (req1_ready) got.push_back(1);
      if (rsp0_valid) begin
        vectors++; if ({rsp_data, rsp_zero} !== {32'h0, 1'b1}) begin miscompares++; $display("FAIL b2b_rsp0 got %h/%b want 0/1", rsp_data, rsp_zero); end
      end
      if (rsp1_valid) begin
        vectors++; if ({rsp_data, rsp_zero} !== {32'hFF, 1'b0}) begin miscompares++; $display("FAIL b2b_rsp1 got %h/%b want ff/0", rsp_data, rsp_zero); end
      end
      tick();
    end
    vectors++; if (got.size() != 4) begin miscompares++; $display("FAIL b2b_accept_count got %0d want 4", got.size()); end
    foreach (got[i]) begin
      vectors++; if (got[i] != (i % 2)) begin miscompares++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, got[i], i % 2); end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (3) tick();
  endtask

  task automatic test_hold();
    RST = 0; #3; RST = 1;
    rsp1_ready = 0;
    req1_valid = 1; req1_srca = 32'd3; req1_srcb = 32'd2; req1_ctrl = 3'b110;
    #1;
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL hold_accept got %b want 1", req1_ready); end
    tick(); req0_valid = 1; req0_srca = 32'd1; req0_srcb = 32'd1; req0_ctrl = 3'b010;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({rsp1_valid, rsp0_valid, rsp_data, rsp_zero} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin miscompares++; $display("FAIL hold_rsp[%0d] got %b%b %h/%b want 10 0/1", i, rsp1_valid, rsp0_valid, rsp_data, rsp_zero); end
      vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL hold_ready[%0d] got %b want 00", i, {req0_ready, req1_ready}); end
      tick();
    end
    req1_valid = 0; rsp1_ready = 1; #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL hold_retire_ready got %b want 00", {req0_ready, req1_ready}); end
    tick();
    vectors++; if ({busy, rsp1_valid, req0_ready} !== 3'b001) begin miscompares++; $display("FAIL hold_idle got %b want 001", {busy, rsp1_valid, req0_ready}); end
    req0_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_op(1'b0, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0);
    test_reset_mid();
    test_back_to_back();
    test_hold();
    test_op(1'b0, 3'b111, 32'd1, 32'd1, 32'd0, 1'b1);
    test_op(1'b1, 3'b101, 32'h10000, 32'h10000, 32'd0, 1'b1);
    test_op(1'b0, 3'b001, 32'hA0, 32'h05, 32'hA5, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
